ring_router_mux_wrr: RTL and testbench

RING_ROUTER_MUX_WRR -- requirements
Module: ring_router_mux_wrr

---
 rtl/ring_router_mux_wrr_if.sv | 10 +
 rtl/ring_router_mux_wrr.sv | 91 +++++++++
 tb/tb_ring_router_mux_wrr.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ring_router_mux_wrr_if.sv
// rtl/ring_router_mux_wrr_if.sv - 16-bit data/valid/last/ready channel used by the ring router mux
interface dii_channel;
    logic [15:0] data;
    logic        valid;
    logic        last;
    logic        ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/ring_router_mux_wrr.sv
// rtl/ring_router_mux_wrr.sv - packet-locked weighted round-robin mux of ring and local traffic
module ring_router_mux_wrr #(
    parameter int RING_WEIGHT  = 4,
    parameter int LOCAL_WEIGHT = 1
) (
    input  logic       clk,
    input  logic       rst,
    dii_channel.slave  in_ring,
    dii_channel.slave  in_local,
    dii_channel.master out,
    output logic       busy,
    output logic       pref_local
);

    if (RING_WEIGHT < 1 || RING_WEIGHT > 255) begin : g_bad_ring_weight
        $error("RING_WEIGHT must be in 1..255");
    end
    if (LOCAL_WEIGHT < 1 || LOCAL_WEIGHT > 255) begin : g_bad_local_weight
        $error("LOCAL_WEIGHT must be in 1..255");
    end

    localparam logic [7:0] RW = 8'(RING_WEIGHT);
    localparam logic [7:0] LW = 8'(LOCAL_WEIGHT);

    typedef enum logic [1:0] {IDLE, LOCK_RING, LOCK_LOCAL} state_t;

    state_t     state, state_nx;
    logic       pref;
    logic [7:0] credit;
    logic       sel_ring, sel_local;
    logic       done, done_pref;

    // In IDLE the preference only matters when both sources compete.
    always_comb begin
        sel_ring  = 1'b0;
        sel_local = 1'b0;
        case (state)
            IDLE: begin
                sel_ring  = in_ring.valid  && (!in_local.valid || !pref);
                sel_local = in_local.valid && (!in_ring.valid  ||  pref);
            end
            LOCK_RING:  sel_ring  = 1'b1;
            LOCK_LOCAL: sel_local = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        out.data       = sel_local ? in_local.data : in_ring.data;
        out.last       = sel_local ? in_local.last : in_ring.last;
        out.valid      = !rst && ((sel_ring && in_ring.valid) || (sel_local && in_local.valid));
        in_ring.ready  = !rst && sel_ring  && out.ready;
        in_local.ready = !rst && sel_local && out.ready;
    end

    assign done      = out.valid && out.ready && out.last;
    assign done_pref = done && (sel_local == pref);

    // Any presented flit that does not finish its packet right now locks the grant.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (out.valid && !done) state_nx = sel_local ? LOCK_LOCAL : LOCK_RING;
            LOCK_RING,
            LOCK_LOCAL: if (done) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pref   <= 1'b0;
            credit <= RW;
        end else begin
            state <= state_nx;
            if (done_pref) begin
                if (credit == 8'd1) begin
                    pref   <= !pref;
                    credit <= pref ? RW : LW;
                end else begin
                    credit <= credit - 8'd1;
                end
            end
        end
    end

    assign busy       = (state != IDLE);
    assign pref_local = pref;

endmodule

// File: tb/tb_ring_router_mux_wrr.sv
// tb/tb_ring_router_mux_wrr.sv - directed self-checking bench for ring_router_mux_wrr
module tb_ring_router_mux_wrr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] r_data, l_data;
    logic        r_valid, r_last, l_valid, l_last, o_ready;
    logic        busy, pref, busy2, pref2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dii_channel ir (), il (), io ();
    dii_channel ir2 (), il2 (), io2 ();

    assign ir.data   = r_data;   assign ir.valid  = r_valid; assign ir.last  = r_last;
    assign il.data   = l_data;   assign il.valid  = l_valid; assign il.last  = l_last;
    assign io.ready  = o_ready;
    assign ir2.data  = r_data;   assign ir2.valid = r_valid; assign ir2.last = r_last;
    assign il2.data  = l_data;   assign il2.valid = l_valid; assign il2.last = l_last;
    assign io2.ready = o_ready;

    ring_router_mux_wrr #(.RING_WEIGHT(4), .LOCAL_WEIGHT(1)) dut (
        .clk(clk), .rst(rst), .in_ring(ir), .in_local(il), .out(io),
        .busy(busy), .pref_local(pref)
    );

    ring_router_mux_wrr #(.RING_WEIGHT(1), .LOCAL_WEIGHT(2)) dut2 (
        .clk(clk), .rst(rst), .in_ring(ir2), .in_local(il2), .out(io2),
        .busy(busy2), .pref_local(pref2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // 0 = nothing accepted, 1 = ring accepted, 2 = local accepted
    function automatic int gnt(input bit two);
        if (two) return (ir2.ready && r_valid) ? 1 : (il2.ready && l_valid) ? 2 : 0;
        return (ir.ready && r_valid) ? 1 : (il.ready && l_valid) ? 2 : 0;
    endfunction

    task automatic sat_run(input string tag, input string exp, input string pexp, input bit two);
        int e;
        for (int i = 0; i < exp.len(); i++) begin
            r_valid = 1'b1; r_last = 1'b1; r_data = 16'hA000 + 16'(i);
            l_valid = 1'b1; l_last = 1'b1; l_data = 16'hB000 + 16'(i);
            o_ready = 1'b1;
            e = (exp[i] == "R") ? 1 : 2;
            @(negedge clk);
            check({tag, "_grant"}, gnt(two), e);
            check({tag, "_pref"}, two ? pref2 : pref, (pexp[i] == "1") ? 1 : 0);
            if (!two) check({tag, "_data"}, io.data, (e == 1) ? 32'hA000 + i : 32'hB000 + i);
            tick();
        end
        r_valid = 1'b0;
        l_valid = 1'b0;
    endtask

    initial begin
        r_data = 16'h0; l_data = 16'h0; r_last = 1'b1; l_last = 1'b1;
        r_valid = 1'b1; l_valid = 1'b1; o_ready = 1'b1;

        // reset state with both sources presenting
        #1;
        check("rst_out_valid", io.valid, 0);
        check("rst_ring_ready", ir.ready, 0);
        check("rst_local_ready", il.ready, 0);
        check("rst_busy", busy, 0);
        check("rst_pref", pref, 0);
        tick();
        rst = 1'b0;

        sat_run("wrr_default", "RRRRLRRRRL", "0000100001", 1'b0);

        // ring 5-flit packet, local arrives at flit 2
        for (int c = 0; c < 6; c++) begin
            r_valid = (c < 5); r_last = (c == 4); r_data = 16'hC000 + 16'(c);
            l_valid = (c >= 1); l_last = 1'b1;    l_data = 16'hD000;
            @(negedge clk);
            if (c < 5) begin
                check("lock_ring_grant", gnt(1'b0), 1);
                check("lock_local_ready", il.ready, 0);
                check("lock_data", io.data, 32'hC000 + c);
                check("lock_busy", busy, (c == 0) ? 0 : 1);
            end else begin
                check("after_ring_grant", gnt(1'b0), 2);
                check("after_ring_busy", busy, 0);
            end
            tick();
        end
        l_valid = 1'b0;

        // local only while ring is preferred: no credit or pref change
        do_reset();
        for (int c = 0; c < 3; c++) begin
            r_valid = 1'b0; l_valid = 1'b1; l_last = 1'b1; l_data = 16'hE000 + 16'(c);
            @(negedge clk);
            check("local_only_grant", gnt(1'b0), 2);
            check("local_only_pref", pref, 0);
            tick();
        end
        sat_run("credit_kept", "RRRRL", "00001", 1'b0);

        // out.ready low in IDLE locks the ring packet
        o_ready = 1'b0; r_valid = 1'b1; r_last = 1'b0; l_valid = 1'b0;
        @(negedge clk);
        check("stall_out_valid", io.valid, 1);
        check("stall_ring_ready", ir.ready, 0);
        check("stall_busy_idle", busy, 0);
        tick();
        l_valid = 1'b1; l_last = 1'b1;
        @(negedge clk);
        check("stall_busy_lock", busy, 1);
        check("stall_local_ready", il.ready, 0);
        tick();
        o_ready = 1'b1;
        @(negedge clk);
        check("stall_ring_go", gnt(1'b0), 1);
        tick();
        r_last = 1'b1;
        @(negedge clk);
        check("stall_ring_last", gnt(1'b0), 1);
        check("stall_out_last", io.last, 1);
        tick();
        r_valid = 1'b0;
        @(negedge clk);
        check("stall_local_after", gnt(1'b0), 2);
        check("stall_busy_after", busy, 0);
        tick();
        l_valid = 1'b0;

        // reset during the 3rd flit of a local packet
        l_valid = 1'b1; l_last = 1'b0;
        @(negedge clk);
        check("abort_flit1", gnt(1'b0), 2);
        tick();
        @(negedge clk);
        check("abort_flit2_busy", busy, 1);
        tick();
        r_valid = 1'b1; r_last = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", io.valid, 0);
        check("abort_ring_ready", ir.ready, 0);
        check("abort_local_ready", il.ready, 0);
        check("abort_busy", busy, 0);
        check("abort_pref", pref, 0);
        tick();
        rst = 1'b0;
        sat_run("after_abort", "RRRRL", "00001", 1'b0);

        // weights ring=1 local=2
        do_reset();
        sat_run("wrr_1_2", "RLLRLLRLL", "011011011", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
